// File: rtl/tune_pkg.sv
// Shared types and constants for the four-note tune player.
package tune_pkg;

    localparam int unsigned CNT_W_DEF = 32;
    localparam int unsigned REP_W_DEF = 8;
    localparam int unsigned NUM_NOTES = 4;
    localparam int unsigned IDX_W     = $clog2(NUM_NOTES);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Note index successor, wrapping after the last note.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles pwm every half_period cycles; half_period 0 is a rest.
module tone_gen #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] half_period,
    output logic             pwm
);

    logic [CNT_W-1:0] tone_cnt_q;
    logic [CNT_W-1:0] tone_cnt_d;
    logic             pwm_q;
    logic             pwm_d;

    always_comb begin : tone_next
        tone_cnt_d = tone_cnt_q;
        pwm_d      = pwm_q;
        if (clr) begin
            tone_cnt_d = '0;
            pwm_d      = 1'b0;
        end else if (en) begin
            if (half_period == '0) begin
                tone_cnt_d = '0;
                pwm_d      = 1'b0;
            end else if (tone_cnt_q == half_period - CNT_W'(1)) begin
                tone_cnt_d = '0;
                pwm_d      = ~pwm_q;
            end else begin
                tone_cnt_d = tone_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin : tone_regs
        if (!reset_n) begin
            tone_cnt_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/tune.sv
// Four-note tune player: latches four notes and a repeat count on start,
// plays them repThreshold times as a square wave, then waits for start to drop.
module tune
    import tune_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] freq0,
    input  logic [CNT_W-1:0] freq1,
    input  logic [CNT_W-1:0] freq2,
    input  logic [CNT_W-1:0] freq3,
    input  logic [CNT_W-1:0] dur0,
    input  logic [CNT_W-1:0] dur1,
    input  logic [CNT_W-1:0] dur2,
    input  logic [CNT_W-1:0] dur3,
    input  logic [REP_W-1:0] repThreshold,
    output logic             makingMusic,
    output logic             pwm
);

    typedef logic [NUM_NOTES-1:0][CNT_W-1:0] note_vec_t;

    state_e           state_q;
    state_e           state_d;
    note_vec_t        freq_q;
    note_vec_t        freq_d;
    note_vec_t        dur_q;
    note_vec_t        dur_d;
    note_vec_t        freq_in_c;
    note_vec_t        dur_in_c;
    logic [REP_W-1:0] rep_thr_q;
    logic [REP_W-1:0] rep_thr_d;
    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] rep_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [CNT_W-1:0] dur_cnt_q;
    logic [CNT_W-1:0] dur_cnt_d;
    logic [CNT_W-1:0] cur_dur_c;
    logic [CNT_W-1:0] note_end_cnt_c;
    logic [CNT_W-1:0] cur_freq_c;
    logic             making_music_q;
    logic             making_music_d;
    logic             start_ok_c;
    logic             note_last_c;
    logic             pass_last_c;
    logic             tone_clr_c;
    logic             tone_en_c;

    assign freq_in_c = {freq3, freq2, freq1, freq0};
    assign dur_in_c  = {dur3, dur2, dur1, dur0};

    // A zero duration plays for one cycle, same as a duration of one.
    assign start_ok_c     = start && (repThreshold != '0);
    assign cur_dur_c      = dur_q[idx_q];
    assign cur_freq_c     = freq_q[idx_q];
    assign note_end_cnt_c = (cur_dur_c == '0) ? '0 : cur_dur_c - CNT_W'(1);
    assign note_last_c    = (dur_cnt_q == note_end_cnt_c);
    assign pass_last_c    = (idx_q == LAST_IDX) && ((rep_q + REP_W'(1)) == rep_thr_q);

    always_ff @(posedge clk) begin : state_reg
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok_c) state_d = PLAY;
            PLAY:    if (note_last_c && pass_last_c) state_d = DONE;
            DONE:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : output_next
        freq_d         = freq_q;
        dur_d          = dur_q;
        rep_thr_d      = rep_thr_q;
        rep_d          = rep_q;
        idx_d          = idx_q;
        dur_cnt_d      = dur_cnt_q;
        making_music_d = (state_d == PLAY);
        tone_en_c      = (state_q == PLAY);
        tone_clr_c     = (state_q != PLAY) || note_last_c;
        unique case (state_q)
            IDLE: begin
                if (start_ok_c) begin
                    freq_d    = freq_in_c;
                    dur_d     = dur_in_c;
                    rep_thr_d = repThreshold;
                    rep_d     = '0;
                    idx_d     = '0;
                    dur_cnt_d = '0;
                end
            end
            PLAY: begin
                if (note_last_c) begin
                    dur_cnt_d = '0;
                    idx_d     = next_idx(idx_q);
                    if (idx_q == LAST_IDX) begin
                        rep_d = pass_last_c ? '0 : rep_q + REP_W'(1);
                    end
                end else begin
                    dur_cnt_d = dur_cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin : data_regs
        if (!reset_n) begin
            freq_q         <= '0;
            dur_q          <= '0;
            rep_thr_q      <= '0;
            rep_q          <= '0;
            idx_q          <= '0;
            dur_cnt_q      <= '0;
            making_music_q <= 1'b0;
        end else begin
            freq_q         <= freq_d;
            dur_q          <= dur_d;
            rep_thr_q      <= rep_thr_d;
            rep_q          <= rep_d;
            idx_q          <= idx_d;
            dur_cnt_q      <= dur_cnt_d;
            making_music_q <= making_music_d;
        end
    end

    tone_gen #(
        .CNT_W (CNT_W)
    ) u_tone_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr         (tone_clr_c),
        .en          (tone_en_c),
        .half_period (cur_freq_c),
        .pwm         (pwm)
    );

    assign makingMusic = making_music_q;

endmodule

// File: tb/tb_tune.sv
// Randomized self-checking bench for tune against a per-cycle note/tone reference model.
module tb_tune;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] freq0, freq1, freq2, freq3;
    logic [31:0] dur0, dur1, dur2, dur3;
    logic [7:0]  repThreshold;
    logic        makingMusic;
    logic        pwm;

    int n_checks = 0;
    int n_pass   = 0;

    int cfg_freq[4];
    int cfg_dur[4];
    int cfg_rep;
    bit exp_q[$];

    tune dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .freq0        (freq0),
        .freq1        (freq1),
        .freq2        (freq2),
        .freq3        (freq3),
        .dur0         (dur0),
        .dur1         (dur1),
        .dur2         (dur2),
        .dur3         (dur3),
        .repThreshold (repThreshold),
        .makingMusic  (makingMusic),
        .pwm          (pwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: each note lasts max(dur,1) cycles; within it pwm is bit 0 of k/freq.
    task automatic build_model();
        exp_q.delete();
        for (int p = 0; p < cfg_rep; p++) begin
            for (int n = 0; n < 4; n++) begin
                int len;
                len = (cfg_dur[n] == 0) ? 1 : cfg_dur[n];
                for (int k = 0; k < len; k++) begin
                    exp_q.push_back((cfg_freq[n] == 0) ? 1'b0 : 1'(((k / cfg_freq[n]) % 2)));
                end
            end
        end
    endtask

    task automatic drive_cfg();
        freq0 = 32'(cfg_freq[0]); freq1 = 32'(cfg_freq[1]);
        freq2 = 32'(cfg_freq[2]); freq3 = 32'(cfg_freq[3]);
        dur0  = 32'(cfg_dur[0]);  dur1  = 32'(cfg_dur[1]);
        dur2  = 32'(cfg_dur[2]);  dur3  = 32'(cfg_dur[3]);
        repThreshold = 8'(cfg_rep);
        start = 1'b1;
    endtask

    task automatic scramble_inputs();
        freq0 = $urandom; freq1 = $urandom; freq2 = $urandom; freq3 = $urandom;
        dur0  = $urandom; dur1  = $urandom; dur2  = $urandom; dur3  = $urandom;
        repThreshold = 8'($urandom);
        start = 1'($urandom_range(0, 1));
    endtask

    // Starts a play from IDLE at a negedge; optionally aborts with reset at a chosen cycle.
    task automatic play(input string name, input bit do_abort);
        int abort_at;
        int mm_len;
        drive_cfg();
        build_model();
        abort_at = do_abort ? $urandom_range(0, exp_q.size() - 1) : -1;
        mm_len = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check_eq($sformatf("%s mm[%0d]", name, i), 32'(makingMusic), 32'd1);
            check_eq($sformatf("%s pwm[%0d]", name, i), 32'(pwm), 32'(exp_q[i]));
            if (makingMusic) mm_len++;
            if (i == abort_at) begin
                reset_n = 1'b0;
                @(negedge clk);
                check_eq($sformatf("%s rst mm", name), 32'(makingMusic), 32'd0);
                check_eq($sformatf("%s rst pwm", name), 32'(pwm), 32'd0);
                reset_n = 1'b1;
                return;
            end
            scramble_inputs();
            if (i == exp_q.size() - 1) start = 1'b1;
        end
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check_eq($sformatf("%s done mm[%0d]", name, j), 32'(makingMusic), 32'd0);
            check_eq($sformatf("%s done pwm[%0d]", name, j), 32'(pwm), 32'd0);
        end
        check_eq($sformatf("%s mm_len", name), 32'(mm_len), 32'(exp_q.size()));
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_cfg(input int f0, input int f1, input int f2, input int f3,
                           input int d0, input int d1, input int d2, input int d3,
                           input int r);
        cfg_freq[0] = f0; cfg_freq[1] = f1; cfg_freq[2] = f2; cfg_freq[3] = f3;
        cfg_dur[0]  = d0; cfg_dur[1]  = d1; cfg_dur[2]  = d2; cfg_dur[3]  = d3;
        cfg_rep = r;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        freq0 = '0; freq1 = '0; freq2 = '0; freq3 = '0;
        dur0  = '0; dur1  = '0; dur2  = '0; dur3  = '0;
        repThreshold = '0;
        repeat (3) @(negedge clk);
        check_eq("reset mm", 32'(makingMusic), 32'd0);
        check_eq("reset pwm", 32'(pwm), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("idle mm", 32'(makingMusic), 32'd0);
        check_eq("idle pwm", 32'(pwm), 32'd0);

        // Nominal run, then retrigger after start drops.
        set_cfg(3, 5, 1, 2, 20, 15, 6, 15, 2);
        play("nominal", 1'b0);
        play("retrigger", 1'b0);

        // Rest note plus zero-duration note.
        set_cfg(4, 0, 3, 2, 5, 7, 0, 4, 1);
        play("rest_zero", 1'b0);

        // Zero repeat count never starts playback.
        set_cfg(3, 3, 3, 3, 4, 4, 4, 4, 0);
        drive_cfg();
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check_eq($sformatf("rep0 mm[%0d]", j), 32'(makingMusic), 32'd0);
            check_eq($sformatf("rep0 pwm[%0d]", j), 32'(pwm), 32'd0);
            freq0 = $urandom; dur0 = $urandom;
        end
        start = 1'b0;
        @(negedge clk);

        // Reset mid-playback, then restart with start held high.
        set_cfg(3, 5, 1, 2, 20, 15, 6, 15, 2);
        play("reset_abort", 1'b1);
        play("after_reset", 1'b0);

        for (int t = 0; t < 20; t++) begin
            set_cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                    $urandom_range(0, 6), $urandom_range(0, 12), $urandom_range(0, 12),
                    $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(1, 3));
            play($sformatf("rand%0d", t), ($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
